// File: rtl/result_mon_pkg.sv
// rtl/result_mon_pkg.sv - shared types and segment constants for the ALU result monitor
package result_mon_pkg;

   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG_BLANK = 7'h7F;
   localparam seg7_t SEG_DASH  = 7'h3F;

   // History index/count types sized for the largest supported DEPTH (16)
   localparam int HIST_DEPTH_MAX = 16;
   typedef logic [$clog2(HIST_DEPTH_MAX)-1:0]   hist_idx_t;
   typedef logic [$clog2(HIST_DEPTH_MAX+1)-1:0] hist_cnt_t;

endpackage

// File: rtl/alu_result_monitor_if.sv
// rtl/alu_result_monitor_if.sv - board-side signal bundle of the ALU result monitor (RESULT_MON_CHG_CNT_EN adds chg_cnt)
interface alu_result_monitor_if;
   import result_mon_pkg::*;

   logic [31:0] alu_result;
   logic        key_next;
   logic        key_prev;
   logic        sw_freeze;
   logic        sw_half;
   seg7_t       hex0;
   seg7_t       hex1;
   seg7_t       hex2;
   seg7_t       hex3;
   seg7_t       hex4;
   seg7_t       hex5;
   logic [9:0]  ledr;
`ifdef RESULT_MON_CHG_CNT_EN
   logic [15:0] chg_cnt;
`endif

   modport master (
`ifdef RESULT_MON_CHG_CNT_EN
      input  chg_cnt,
`endif
      output alu_result, key_next, key_prev, sw_freeze, sw_half,
      input  hex0, hex1, hex2, hex3, hex4, hex5, ledr
   );

   modport slave (
`ifdef RESULT_MON_CHG_CNT_EN
      output chg_cnt,
`endif
      input  alu_result, key_next, key_prev, sw_freeze, sw_half,
      output hex0, hex1, hex2, hex3, hex4, hex5, ledr
   );

endinterface

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - 4-bit value to active-low seven-segment {g..a} decoder
module hex7seg
   import result_mon_pkg::*;
(
   input  logic [3:0] digit,
   output seg7_t      seg
);

   // Active-low glyph lookup, lower-case b and d to keep them distinct from 8 and 0
   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
   end

endmodule

// File: rtl/result_mon_debounce.sv
// rtl/result_mon_debounce.sv - push-button debouncer producing a one-cycle press pulse on 1->0
module result_mon_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic press
);

   localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] stable_cnt;
   logic          accepted;

   // Accept a new level only after it has differed from the accepted one for DEBOUNCE_CYCLES samples in a row
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stable_cnt <= '0;
         accepted   <= 1'b0;
         press      <= 1'b0;
      end else begin
         press <= 1'b0;
         if (level == accepted) begin
            stable_cnt <= '0;
         end else if (stable_cnt == LAST) begin
            stable_cnt <= '0;
            accepted   <= level;
            press      <= accepted & ~level;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_result_monitor.sv
// rtl/alu_result_monitor.sv - ALU result history capture/browse with 7-seg display (RESULT_MON_CHG_CNT_EN adds capture counter)
module alu_result_monitor
   import result_mon_pkg::*;
#(
   parameter int DEPTH           = 8,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SYNC_STAGES     = 2
) (
   input logic                 clk,
   input logic                 rst,
   alu_result_monitor_if.slave mon
);

   localparam int        IW       = $clog2(DEPTH);
   localparam hist_cnt_t CNT_FULL = hist_cnt_t'(DEPTH);

   typedef logic [IW-1:0] ptr_t;

   // ---------------- input synchronizers ----------------
   // bit 3 key_next, bit 2 key_prev, bit 1 sw_freeze, bit 0 sw_half
   logic [3:0] sync_q [SYNC_STAGES];
   logic [3:0] sync_out;
   logic       frozen_s;
   logic       half_s;

   // Shift every asynchronous board input through the synchronizer chain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {mon.key_next, mon.key_prev, mon.sw_freeze, mon.sw_half};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign frozen_s = sync_out[1];
   assign half_s   = sync_out[0];

   // ---------------- key debounce ----------------
   logic press_next;
   logic press_prev;

   result_mon_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
      .clk   (clk),
      .rst   (rst),
      .level (sync_out[3]),
      .press (press_next)
   );

   result_mon_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
      .clk   (clk),
      .rst   (rst),
      .level (sync_out[2]),
      .press (press_prev)
   );

   // ---------------- history capture ----------------
   logic [31:0] mem [DEPTH];
   ptr_t        wr_ptr;
   hist_cnt_t   count;
   logic        overflow;
   logic        last_valid;
   logic [31:0] last_value;
   logic        capture;

   assign capture = !frozen_s && (!last_valid || (mon.alu_result != last_value));

   // Record each new ALU value into the circular history; the oldest entry is overwritten once full
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         last_valid <= 1'b0;
         last_value <= '0;
      end else if (capture) begin
         mem[wr_ptr] <= mon.alu_result;
         wr_ptr      <= wr_ptr + 1'b1;
         last_value  <= mon.alu_result;
         last_valid  <= 1'b1;
         if (count != CNT_FULL) count <= count + 1'b1;
         else                   overflow <= 1'b1;
      end
   end

`ifdef RESULT_MON_CHG_CNT_EN
   logic [15:0] chg_cnt_q;

   // Free-running count of captures, wraps naturally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         chg_cnt_q <= '0;
      else if (capture) chg_cnt_q <= chg_cnt_q + 1'b1;
   end

   assign mon.chg_cnt = chg_cnt_q;
`endif

   // ---------------- browse ----------------
   hist_idx_t view_offset;

   // Live mode pins the view to the newest entry; frozen mode steps through history on single presses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         view_offset <= '0;
      end else if (!frozen_s) begin
         view_offset <= '0;
      end else if ((count != '0) && (press_next ^ press_prev)) begin
         if (press_next && (hist_cnt_t'(view_offset) != count - 1'b1))
            view_offset <= view_offset + 1'b1;
         else if (press_prev && (view_offset != '0))
            view_offset <= view_offset - 1'b1;
      end
   end

   // ---------------- display ----------------
   ptr_t        sel_idx;
   logic [31:0] sel_word;
   logic [15:0] half_word;
   logic [7:0]  top_byte;
   logic [23:0] digits;
   seg7_t       seg_d [6];
   seg7_t       hex_q [6];
   logic [9:0]  ledr_q;

   assign sel_idx   = wr_ptr - 1'b1 - view_offset[IW-1:0];
   assign sel_word  = mem[sel_idx];
   assign half_word = half_s ? sel_word[31:16] : sel_word[15:0];

`ifdef RESULT_MON_CHG_CNT_EN
   assign top_byte = frozen_s ? {4'h0, view_offset} : chg_cnt_q[7:0];
`else
   assign top_byte = {4'h0, view_offset};
`endif

   assign digits = {top_byte, half_word};

   for (genvar g = 0; g < 6; g++) begin : g_dig
      hex7seg u_dec (
         .digit (digits[g*4 +: 4]),
         .seg   (seg_d[g])
      );
   end

   // Register all display outputs; an empty history shows dashes with the offset digits blank
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
         ledr_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) hex_q[i] <= (count == '0) ? SEG_DASH : seg_d[i];
         for (int i = 4; i < 6; i++) hex_q[i] <= (count == '0) ? SEG_BLANK : seg_d[i];
         ledr_q <= {overflow, frozen_s, 3'b000, count};
      end
   end

   assign mon.hex0 = hex_q[0];
   assign mon.hex1 = hex_q[1];
   assign mon.hex2 = hex_q[2];
   assign mon.hex3 = hex_q[3];
   assign mon.hex4 = hex_q[4];
   assign mon.hex5 = hex_q[5];
   assign mon.ledr = ledr_q;

endmodule
